task_7_reverse: RTL

- Downstream stage of the task 7 input FIFO reader. It consumes the byte burst the reader emits on its data/valid outputs.
- Buffers one burst, up to DEPTH bytes, then replays it in reverse order on an AXI-Stream-style master with tvalid/tready/tlast.
- Marks the packet end with tlast, reports the captured length, and flags overflow and dropped bytes.
- Sits between the input stage and the task 7 output/transmit stage.

---
 rtl/task_7_reverse_if.sv | 20 ++
 rtl/task_7_reverse.sv | 125 ++++++++++++
 2 files changed

// File: rtl/task_7_reverse_if.sv
// Byte stream bundle for the task 7 reverser: burst input from the reader
// plus the AXI-Stream-style reversed output.
interface task_7_reverse_if;
    logic [7:0] i_data;
    logic       i_valid;
    logic [7:0] o_tdata;
    logic       o_tvalid;
    logic       o_tlast;
    logic       i_tready;

    modport master (
        input  i_data, i_valid, i_tready,
        output o_tdata, o_tvalid, o_tlast
    );

    modport slave (
        output i_data, i_valid, i_tready,
        input  o_tdata, o_tvalid, o_tlast
    );
endinterface

// File: rtl/task_7_reverse.sv
// Captures one input burst of up to DEPTH bytes and replays it newest-first
// as a stream packet terminated by tlast.
module task_7_reverse #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    task_7_reverse_if.master    bus,
    output logic                o_busy,
    output logic [ADDR_W:0]     o_len,
    output logic                o_overflow,
    output logic [7:0]          o_drop_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    state_t              state;
    state_t              state_next;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W:0]     wcnt;
    logic [ADDR_W-1:0]   rptr;
    logic                fire;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Output byte is read straight from the buffer so it holds while stalled.
    always_comb begin
        state_next   = state;
        o_busy       = 1'b0;
        bus.o_tvalid = 1'b0;
        bus.o_tlast  = 1'b0;
        bus.o_tdata  = '0;
        fire         = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_valid) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                o_busy = 1'b1;
                if (!bus.i_valid) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                o_busy       = 1'b1;
                bus.o_tvalid = 1'b1;
                bus.o_tdata  = mem[rptr];
                bus.o_tlast  = (rptr == '0);
                fire         = bus.i_tready;
                if (fire && rptr == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (state == IDLE && bus.i_valid) begin
            mem[0] <= bus.i_data;
        end else if (state == COLLECT && bus.i_valid && wcnt < FULL) begin
            mem[wcnt[ADDR_W-1:0]] <= bus.i_data;
        end
    end

    // Bytes beyond DEPTH are discarded but remembered via the sticky overflow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wcnt       <= '0;
            rptr       <= '0;
            o_len      <= '0;
            o_overflow <= 1'b0;
            o_drop_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        wcnt       <= (ADDR_W+1)'(1);
                        o_overflow <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (bus.i_valid) begin
                        if (wcnt < FULL) begin
                            wcnt <= wcnt + (ADDR_W+1)'(1);
                        end else begin
                            o_overflow <= 1'b1;
                        end
                    end else begin
                        o_len <= wcnt;
                        rptr  <= ADDR_W'(wcnt - (ADDR_W+1)'(1));
                    end
                end
                EMIT: begin
                    if (fire && rptr != '0) begin
                        rptr <= rptr - ADDR_W'(1);
                    end
                    if (bus.i_valid && o_drop_cnt != 8'hFF) begin
                        o_drop_cnt <= o_drop_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
